// File: rtl/ldpc_seg_sched_if.sv
// ============================================================================
// Module   : ldpc_seg_sched_if
// Purpose  : Frame-request, segmenter handshake and status bundle for the
//            LDPC segment scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ldpc_seg_sched_if #(
  parameter int TMO_W = 20
);
  logic             i_frm_start;
  logic [7:0]       i_frm_nblk;
  logic [1:0]       i_frm_mode;
  logic             i_abort;
  logic [TMO_W-1:0] i_tmo_limit;
  logic             i_st_done;
  logic             o_st_start;
  logic [19:0]      o_st_opt;
  logic             o_busy;
  logic [7:0]       o_blk_idx;
  logic             o_frm_done;
  logic             o_frm_err;
  logic [1:0]       o_err_code;

  modport master (
    output i_frm_start, i_frm_nblk, i_frm_mode, i_abort, i_tmo_limit, i_st_done,
    input  o_st_start, o_st_opt, o_busy, o_blk_idx, o_frm_done, o_frm_err,
           o_err_code
  );

  modport slave (
    input  i_frm_start, i_frm_nblk, i_frm_mode, i_abort, i_tmo_limit, i_st_done,
    output o_st_start, o_st_opt, o_busy, o_blk_idx, o_frm_done, o_frm_err,
           o_err_code
  );
endinterface

`default_nettype wire

// File: rtl/ldpc_seg_sched.sv
// ============================================================================
// Module   : ldpc_seg_sched
// Purpose  : Splits a frame request into LDPC code blocks, issues one segment
//            start per block with a watchdog and inter-block gap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ldpc_seg_sched #(
  parameter logic [17:0] SEG_M0  = 18'd809,
  parameter logic [17:0] SEG_M1  = 18'd1079,
  parameter logic [17:0] SEG_M2  = 18'd1214,
  parameter logic [17:0] SEG_M3  = 18'd1349,
  parameter int          GAP_CYC = 4,
  parameter int          TMO_W   = 20
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  ldpc_seg_sched_if.slave   bus
);

  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       nblk_q, nblk_d;
  logic [7:0]       blk_idx_q, blk_idx_d;
  logic [19:0]      st_opt_q, st_opt_d;
  logic [TMO_W-1:0] wdog_q, wdog_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             st_start_q, st_start_d;
  logic             busy_q, busy_d;
  logic             frm_done_q, frm_done_d;
  logic             frm_err_q, frm_err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic [17:0]      w_segmax;
  logic [TMO_W-1:0] w_wdog_inc;
  logic             w_last_blk;
  logic             w_tmo_hit;

  always_comb begin
    w_segmax = SEG_M0;
    case (bus.i_frm_mode)
      2'd0:    w_segmax = SEG_M0;
      2'd1:    w_segmax = SEG_M1;
      2'd2:    w_segmax = SEG_M2;
      default: w_segmax = SEG_M3;
    endcase
  end

  // Watchdog value including the current WAIT cycle; saturates at all-ones.
  assign w_wdog_inc = (wdog_q == {TMO_W{1'b1}}) ? wdog_q : wdog_q + TMO_W'(1);
  assign w_last_blk = (blk_idx_q == nblk_q - 8'd1);
  assign w_tmo_hit  = (bus.i_tmo_limit != '0) && (w_wdog_inc == bus.i_tmo_limit);

  always_comb begin
    state_d    = state_q;
    nblk_d     = nblk_q;
    blk_idx_d  = blk_idx_q;
    st_opt_d   = st_opt_q;
    wdog_d     = wdog_q;
    gap_d      = gap_q;
    err_code_d = err_code_q;
    st_start_d = 1'b0;
    frm_done_d = 1'b0;
    frm_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_frm_start) begin
          if (bus.i_frm_nblk == 8'd0) begin
            frm_err_d  = 1'b1;
            err_code_d = 2'b01;
          end else begin
            nblk_d     = bus.i_frm_nblk;
            st_opt_d   = {w_segmax, bus.i_frm_mode};
            blk_idx_d  = 8'd0;
            err_code_d = 2'b00;
            st_start_d = 1'b1;
            state_d    = S_START;
          end
        end
      end

      S_START: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        wdog_d = w_wdog_inc;
        if (bus.i_st_done) begin
          if (w_last_blk) begin
            state_d = S_DONE;
          end else begin
            blk_idx_d = blk_idx_q + 8'd1;
            gap_d     = GW'(GAP_CYC);
            state_d   = S_GAP;
          end
        end else if (w_tmo_hit) begin
          frm_err_d  = 1'b1;
          err_code_d = 2'b10;
          state_d    = S_IDLE;
        end
      end

      // The final GAP cycle is a hand-off, so done-to-start is GAP_CYC+2.
      S_GAP: begin
        if (gap_q == '0) begin
          st_start_d = 1'b1;
          state_d    = S_START;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      S_DONE: begin
        if (!frm_done_q) begin
          frm_done_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && bus.i_abort) begin
      state_d    = S_IDLE;
      blk_idx_d  = blk_idx_q;
      st_start_d = 1'b0;
      frm_done_d = 1'b0;
      frm_err_d  = 1'b1;
      err_code_d = 2'b11;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      nblk_q     <= 8'd0;
      blk_idx_q  <= 8'd0;
      st_opt_q   <= 20'd0;
      wdog_q     <= '0;
      gap_q      <= '0;
      st_start_q <= 1'b0;
      busy_q     <= 1'b0;
      frm_done_q <= 1'b0;
      frm_err_q  <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      nblk_q     <= nblk_d;
      blk_idx_q  <= blk_idx_d;
      st_opt_q   <= st_opt_d;
      wdog_q     <= wdog_d;
      gap_q      <= gap_d;
      st_start_q <= st_start_d;
      busy_q     <= busy_d;
      frm_done_q <= frm_done_d;
      frm_err_q  <= frm_err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.o_st_start = st_start_q;
  assign bus.o_st_opt   = st_opt_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_blk_idx  = blk_idx_q;
  assign bus.o_frm_done = frm_done_q;
  assign bus.o_frm_err  = frm_err_q;
  assign bus.o_err_code = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_ldpc_seg_sched.sv
// ============================================================================
// Module   : tb_ldpc_seg_sched
// Purpose  : Directed self-checking bench for the LDPC segment scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ldpc_seg_sched;
  localparam int TMO_W = 20;

  logic clk = 1'b0;
  logic reset_n;
  int   nvec = 0;
  int   nmis = 0;

  logic [17:0] segs  [3] = '{18'd809, 18'd1079, 18'd1349};
  logic [1:0]  modes [3] = '{2'd0, 2'd1, 2'd3};
  logic [19:0] exp_opt;

  ldpc_seg_sched_if #(.TMO_W(TMO_W)) bus ();

  ldpc_seg_sched #(
    .SEG_M0 (18'd809),
    .SEG_M1 (18'd1079),
    .SEG_M2 (18'd1214),
    .SEG_M3 (18'd1349),
    .GAP_CYC(4),
    .TMO_W  (TMO_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [7:0] nblk, input logic [1:0] mode);
    bus.i_frm_start = 1'b1;
    bus.i_frm_nblk  = nblk;
    bus.i_frm_mode  = mode;
    tick();
    bus.i_frm_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset_n         = 1'b0;
    bus.i_frm_start = 1'b0;
    bus.i_frm_nblk  = 8'd0;
    bus.i_frm_mode  = 2'd0;
    bus.i_abort     = 1'b0;
    bus.i_tmo_limit = '0;
    bus.i_st_done   = 1'b0;
    tick();
    tick();
    chk("rst_start", bus.o_st_start, 0);
    chk("rst_opt",   bus.o_st_opt,   0);
    chk("rst_busy",  bus.o_busy,     0);
    chk("rst_idx",   bus.o_blk_idx,  0);
    chk("rst_done",  bus.o_frm_done, 0);
    chk("rst_err",   bus.o_frm_err,  0);
    chk("rst_code",  bus.o_err_code, 0);
    reset_n = 1'b1;
    tick();

    // Stray done while idle
    bus.i_st_done = 1'b1;
    tick();
    bus.i_st_done = 1'b0;
    chk("stray_busy",  bus.o_busy,     0);
    chk("stray_start", bus.o_st_start, 0);
    chk("stray_err",   bus.o_frm_err,  0);
    chk("stray_done",  bus.o_frm_done, 0);

    // Zero block count
    req(8'd0, 2'd2);
    chk("zero_err",   bus.o_frm_err,  1);
    chk("zero_code",  bus.o_err_code, 2'b01);
    chk("zero_busy",  bus.o_busy,     0);
    chk("zero_start", bus.o_st_start, 0);
    tick();
    chk("zero_err_pulse", bus.o_frm_err,  0);
    chk("zero_code_held", bus.o_err_code, 2'b01);

    // Normal frame: 3 blocks, mode 2, done 50 cycles after each start
    req(8'd3, 2'd2);
    chk("nf_busy", bus.o_busy,     1);
    chk("nf_code", bus.o_err_code, 0);
    for (int b = 0; b < 3; b++) begin
      chk("nf_start", bus.o_st_start, 1);
      chk("nf_idx",   bus.o_blk_idx,  b);
      chk("nf_opt",   bus.o_st_opt,   {18'd1214, 2'd2});
      repeat (10) tick();
      bus.i_frm_start = (b == 0);
      bus.i_frm_nblk  = 8'd7;
      bus.i_frm_mode  = 2'd1;
      tick();
      bus.i_frm_start = 1'b0;
      tick();
      chk("nf_opt_hold", bus.o_st_opt,   {18'd1214, 2'd2});
      chk("nf_nostart",  bus.o_st_start, 0);
      repeat (38) tick();
      bus.i_st_done = 1'b1;
      tick();
      bus.i_st_done = 1'b0;
      if (b < 2) begin
        repeat (4) tick();
        chk("nf_gap_quiet", bus.o_st_start, 0);
        tick();
      end else begin
        chk("nf_done_early", bus.o_frm_done, 0);
        chk("nf_busy_tail",  bus.o_busy,     1);
        tick();
        chk("nf_done",      bus.o_frm_done, 1);
        chk("nf_done_err",  bus.o_frm_err,  0);
        chk("nf_done_busy", bus.o_busy,     1);
        tick();
        chk("nf_idle",      bus.o_busy,     0);
        chk("nf_done_off",  bus.o_frm_done, 0);
      end
    end

    // Mode table with single-block frames
    for (int i = 0; i < 3; i++) begin
      req(8'd1, modes[i]);
      exp_opt = {segs[i], modes[i]};
      chk("mt_start", bus.o_st_start, 1);
      chk("mt_opt",   bus.o_st_opt,   exp_opt);
      repeat (5) tick();
      bus.i_st_done = 1'b1;
      tick();
      bus.i_st_done = 1'b0;
      tick();
      chk("mt_done", bus.o_frm_done, 1);
      tick();
      chk("mt_idle", bus.o_busy, 0);
    end

    // Watchdog timeout at limit 100
    bus.i_tmo_limit = 20'd100;
    req(8'd1, 2'd0);
    chk("to_start", bus.o_st_start, 1);
    repeat (100) tick();
    chk("to_early_err", bus.o_frm_err, 0);
    chk("to_early_busy", bus.o_busy,   1);
    tick();
    chk("to_err",  bus.o_frm_err,  1);
    chk("to_code", bus.o_err_code, 2'b10);
    chk("to_busy", bus.o_busy,     0);
    chk("to_done", bus.o_frm_done, 0);
    tick();
    chk("to_err_pulse", bus.o_frm_err,  0);
    chk("to_code_held", bus.o_err_code, 2'b10);

    // Done coinciding with the watchdog reaching the limit
    req(8'd1, 2'd0);
    chk("td_code_clr", bus.o_err_code, 0);
    repeat (100) tick();
    bus.i_st_done = 1'b1;
    tick();
    bus.i_st_done = 1'b0;
    chk("td_noerr", bus.o_frm_err, 0);
    chk("td_busy",  bus.o_busy,    1);
    tick();
    chk("td_done",   bus.o_frm_done, 1);
    chk("td_noerr2", bus.o_frm_err,  0);
    tick();
    bus.i_tmo_limit = '0;

    // Abort during the second gap, then immediate new frame
    req(8'd4, 2'd2);
    repeat (10) tick();
    bus.i_st_done = 1'b1;
    tick();
    bus.i_st_done = 1'b0;
    repeat (5) tick();
    chk("ab_start1", bus.o_st_start, 1);
    chk("ab_idx1",   bus.o_blk_idx,  1);
    repeat (10) tick();
    bus.i_st_done = 1'b1;
    tick();
    bus.i_st_done = 1'b0;
    tick();
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("ab_err",   bus.o_frm_err,  1);
    chk("ab_code",  bus.o_err_code, 2'b11);
    chk("ab_busy",  bus.o_busy,     0);
    chk("ab_start", bus.o_st_start, 0);
    req(8'd1, 2'd3);
    chk("ab_new_start", bus.o_st_start, 1);
    chk("ab_new_busy",  bus.o_busy,     1);
    chk("ab_new_opt",   bus.o_st_opt,   {18'd1349, 2'd3});
    chk("ab_new_code",  bus.o_err_code, 0);
    chk("ab_new_idx",   bus.o_blk_idx,  0);
    tick();
    tick();
    chk("ab_no_stale_start", bus.o_st_start, 0);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("abw_err",  bus.o_frm_err,  1);
    chk("abw_code", bus.o_err_code, 2'b11);
    chk("abw_busy", bus.o_busy,     0);

    // Asynchronous reset in the middle of the second block's WAIT
    req(8'd2, 2'd1);
    repeat (5) tick();
    bus.i_st_done = 1'b1;
    tick();
    bus.i_st_done = 1'b0;
    repeat (5) tick();
    chk("mr_start1", bus.o_st_start, 1);
    chk("mr_idx1",   bus.o_blk_idx,  1);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("mr_start", bus.o_st_start, 0);
    chk("mr_opt",   bus.o_st_opt,   0);
    chk("mr_busy",  bus.o_busy,     0);
    chk("mr_idx",   bus.o_blk_idx,  0);
    chk("mr_done",  bus.o_frm_done, 0);
    chk("mr_err",   bus.o_frm_err,  0);
    chk("mr_code",  bus.o_err_code, 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("mr_post_start", bus.o_st_start, 0);
    chk("mr_post_busy",  bus.o_busy,     0);
    chk("mr_post_err",   bus.o_frm_err,  0);
    chk("mr_post_done",  bus.o_frm_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/ldpc_seg_sched.md
# ldpc_seg_sched

Frame-level sequencer for the transmitter stream-to-LDPC segmenter. It accepts one frame request (block count plus LDPC mode) and splits it into LDPC code blocks. For each block it issues one segment start with the per-mode segment length, then waits for the segmenter's done pulse. It inserts a programmable gap between blocks and reports frame completion, timeout or abort to the MAC-side controller.

## Interface
Parameters:
- SEG_M0, 18'd809, segment length minus 1 (bytes) for LDPC mode 0
- SEG_M1, 18'd1079, same for mode 1
- SEG_M2, 18'd1214, same for mode 2
- SEG_M3, 18'd1349, same for mode 3
- GAP_CYC, 4, idle cycles between a block's done and the next start (0 allowed)
- TMO_W, 20, width of the per-block watchdog counter

Ports:
- clk  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- i_frm_start  input  1  one-cycle frame request; accepted only in IDLE
- i_frm_nblk  input  8  blocks in frame; sampled with i_frm_start
- i_frm_mode  input  2  LDPC mode; sampled with i_frm_start
- i_abort  input  1  abort the current frame
- i_tmo_limit  input  TMO_W  watchdog limit in cycles; 0 disables the watchdog
- i_st_done  input  1  segment-done pulse from the segmenter
- o_st_start  output  1  one-cycle segment start to the segmenter
- o_st_opt  output  20  {segmax[17:0], mode[1:0]} to the segmenter
- o_busy  output  1  high in any state other than IDLE
- o_blk_idx  output  8  index of the current block, 0-based
- o_frm_done  output  1  one-cycle pulse when the frame completes normally
- o_frm_err  output  1  one-cycle error pulse
- o_err_code  output  2  01 zero nblk, 10 timeout, 11 abort; held until the next frame is accepted

## Operation
- States: IDLE, START, WAIT, GAP, DONE.
- IDLE, i_frm_start=1, i_frm_nblk=0: pulse o_frm_err with code 01 and stay in IDLE.
- IDLE, i_frm_start=1, i_frm_nblk!=0:
  - Latch nblk and mode.
  - Latch segmax from SEG_M[mode].
  - Clear blk_idx and err_code.
  - Go to START.
- START: assert o_st_start for exactly one cycle, clear the watchdog, go to WAIT.
- WAIT:
  - Watchdog counts up by 1 per cycle; it saturates and never wraps.
  - On i_st_done with blk_idx==nblk-1: go to DONE.
  - On i_st_done with other blk_idx: increment blk_idx and go to GAP; if GAP_CYC==0, go directly to START.
  - If i_tmo_limit!=0 and the watchdog equals i_tmo_limit with no i_st_done that cycle: pulse o_frm_err with code 10 and go to IDLE.
  - If i_st_done and the timeout hit in the same cycle, done wins.
- GAP: a counter runs GAP_CYC cycles, then goes to START.
- DONE: pulse o_frm_done for one cycle, then go to IDLE.
- i_abort in any non-IDLE state:
  - Next state is IDLE.
  - Pulse o_frm_err with code 11.
  - Suppress any o_st_start or o_frm_done scheduled for that cycle.
  - i_abort in IDLE is ignored.
  - Abort takes priority over done and timeout.
- i_frm_start outside IDLE is ignored, with no latch and no error.
- i_st_done outside WAIT is ignored.
- o_st_opt is registered and stable from the o_st_start cycle until the frame ends. It changes only on frame acceptance.

## Timing
- Reset values: o_st_start=0, o_st_opt=0, o_busy=0, o_blk_idx=0, o_frm_done=0, o_frm_err=0, o_err_code=0, state=IDLE.
- All outputs are registered; none has a combinational path from any input.
- i_frm_start at cycle T: o_busy=1 and o_st_start=1 at T+1.
- i_st_done at cycle D (not last block): o_st_start at D+GAP_CYC+2. With GAP_CYC=0 it is at D+2.
- i_st_done at cycle D (last block): o_frm_done at D+2, then o_busy=0 at D+3.
- Timeout or abort detected at cycle E: o_frm_err at E+1, and o_busy=0 at E+1.
- Zero-nblk request at T: o_frm_err at T+1 and o_busy stays 0.
- A new i_frm_start is accepted in the first cycle where o_busy=0.
- Asynchronous reset mid-frame: all outputs return to reset values immediately. No pulse is emitted after reset release.

## Test plan
- Normal frame: nblk=3, mode=2, GAP_CYC=4, i_st_done 50 cycles after each start -> three o_st_start pulses with o_st_opt={18'd1214,2'd2}, starts spaced 56 cycles apart, o_blk_idx 0,1,2, and one o_frm_done at done+2.
- Mode table: frames with mode 0,1,3, nblk=1 -> o_st_opt segmax equals 809, 1079 and 1349 respectively, with the mode field matching.
- Timeout: i_tmo_limit=100 and no i_st_done -> o_frm_err with o_err_code=10 exactly 101 cycles after o_st_start, no o_frm_done, o_busy=0.
- Timeout and done in the same cycle: i_st_done coincides with the watchdog reaching 100 on the last block -> o_frm_done, no error.
- Abort in GAP: nblk=4, abort during the second gap -> no further o_st_start, o_frm_err with code 11 at abort+1. A new frame is accepted on the next cycle.
- Rejects and ignores:
  - nblk=0 -> error code 01, no o_st_start.
  - i_frm_start while busy -> ignored, with o_st_opt unchanged.
  - Stray i_st_done in IDLE -> no output change.
  - Reset asserted mid-WAIT -> all outputs at their reset values.
